// File: rtl/video_pkg.sv
// Shared types and constants for the video line buffer.
//   PXL_DW / LINE_AW / H_ACTIVE / PXL_TRANSP : default geometry and clear value
//   pixel_t, lineaddr_t                      : pixel and column types
//   fsm_state_t                              : line buffer controller states
package video_pkg;

  localparam int PXL_DW   = 8;
  localparam int LINE_AW  = 9;
  localparam int H_ACTIVE = 320;

  typedef logic [PXL_DW-1:0]  pixel_t;
  typedef logic [LINE_AW-1:0] lineaddr_t;

  localparam pixel_t PXL_TRANSP = '0;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } fsm_state_t;

endpackage

// File: rtl/linebuf_bank.sv
// Single-port synchronous line RAM, 2^AW x DW.
//   clk  : clock
//   we   : write enable (write has priority over read)
//   en   : read enable; dout only updates on a read and holds otherwise
//   addr : word address
//   din  : write data
//   dout : registered read data
module linebuf_bank
  import video_pkg::*;
#(
  parameter int DW = PXL_DW,
  parameter int AW = LINE_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= din;
    else if (en)
      dout <= mem[addr];
  end

endmodule

// File: rtl/video_linebuf.sv
// Ping-pong pixel line buffer. The renderer fills wr_bank for the next line
// while rd_bank is scanned out against hpos; the banks swap on each hblank
// entry and every scanned pixel is cleared behind the beam.
//   clk, reset        : pixel-domain clock, async active-high reset
//   pxl_cen           : pixel clock enable (assumed never high on two
//                       consecutive clks, so a clear never meets a read)
//   lhbl, lvbl        : horizontal / vertical blank, active low
//   hpos              : scan-out column
//   wr_en/addr/data   : renderer pixel write, one per clk
//   busy              : init sweep running, writes ignored
//   line_start        : one-clk pulse on bank swap
//   wr_bank           : bank owned by the renderer
//   rd_data, rd_valid : scanned pixel and its active-area flag
module video_linebuf
  import video_pkg::*;
#(
  parameter int          DW      = PXL_DW,
  parameter int          AW      = LINE_AW,
  parameter int          HACTIVE = H_ACTIVE,
  parameter logic [DW-1:0] TRANSP = PXL_TRANSP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pxl_cen,
  input  logic          lhbl,
  input  logic          lvbl,
  input  logic [8:0]    hpos,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          line_start,
  output logic          wr_bank,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);

  localparam logic [8:0]    HACT_H    = 9'(HACTIVE);
  localparam logic [AW-1:0] HACT_A    = AW'(HACTIVE);
  localparam logic [AW-1:0] SWEEP_END = AW'(HACTIVE - 1);

  fsm_state_t    state;
  logic          rd_bank;
  logic          lhbl_q;
  logic [AW-1:0] sweep;

  logic          rd_now;
  logic          wr_ok;

  logic          clr_vld_p1;
  logic          rd_sel_p1;
  logic [AW-1:0] clr_addr_p1;

  logic          we_b   [2];
  logic          en_b   [2];
  logic [AW-1:0] addr_b [2];
  logic [DW-1:0] din_b  [2];
  logic [DW-1:0] dout_b [2];

  assign wr_bank = ~rd_bank;
  assign rd_now  = (state == ST_RUN) && pxl_cen && lhbl && lvbl && (hpos < HACT_H);
  assign wr_ok   = (state == ST_RUN) && wr_en && (wr_addr < HACT_A) && (wr_data != TRANSP);

  // Stage p0: controller, bank swap and read issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      busy       <= 1'b1;
      rd_bank    <= 1'b0;
      lhbl_q     <= 1'b0;
      line_start <= 1'b0;
      rd_valid   <= 1'b0;
      rd_sel_p1  <= 1'b0;
      clr_vld_p1 <= 1'b0;
      sweep      <= '0;
    end else begin
      line_start <= 1'b0;
      clr_vld_p1 <= rd_now;
      if (pxl_cen)
        lhbl_q <= lhbl;
      case (state)
        ST_INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == SWEEP_END) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pxl_cen) begin
            if (lhbl_q && !lhbl) begin
              rd_bank    <= ~rd_bank;
              line_start <= 1'b1;
            end
            rd_valid <= rd_now;
            if (rd_now)
              rd_sel_p1 <= rd_bank;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Stage p1: latched column for the clear-behind write
  always_ff @(posedge clk) begin
    if (rd_now)
      clr_addr_p1 <= AW'(hpos);
  end

  // Port steering: the sweep owns both banks in INIT; otherwise the writer
  // only ever hits wr_bank and the read/clear only ever hit rd_bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we_b[b]   = 1'b0;
      en_b[b]   = 1'b0;
      addr_b[b] = sweep;
      din_b[b]  = TRANSP;
    end
    if (state == ST_INIT) begin
      for (int b = 0; b < 2; b++)
        we_b[b] = 1'b1;
    end else begin
      if (wr_ok) begin
        we_b[wr_bank]   = 1'b1;
        addr_b[wr_bank] = wr_addr;
        din_b[wr_bank]  = wr_data;
      end
      if (rd_now) begin
        en_b[rd_bank]   = 1'b1;
        addr_b[rd_bank] = AW'(hpos);
      end
      // The clear uses the bank latched at read time, so a swap on this
      // clk cannot redirect it into the renderer's bank.
      if (clr_vld_p1) begin
        we_b[rd_sel_p1]   = 1'b1;
        addr_b[rd_sel_p1] = clr_addr_p1;
        din_b[rd_sel_p1]  = TRANSP;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    linebuf_bank #(.DW(DW), .AW(AW)) u_bank (
      .clk  (clk),
      .we   (we_b[b]),
      .en   (en_b[b]),
      .addr (addr_b[b]),
      .din  (din_b[b]),
      .dout (dout_b[b])
    );
  end

  // RAM dout only moves on a read, so this output holds between pxl_cen ticks.
  assign rd_data = rd_valid ? dout_b[rd_sel_p1] : TRANSP;

endmodule

// File: tb/tb_video_linebuf.sv
module tb_video_linebuf;

  logic       clk = 1'b0;
  logic       reset;
  logic       pxl_cen;
  logic       lhbl;
  logic       lvbl;
  logic [8:0] hpos;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       line_start;
  logic       wr_bank;
  logic [7:0] rd_data;
  logic       rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_linebuf dut (
    .clk        (clk),
    .reset      (reset),
    .pxl_cen    (pxl_cen),
    .lhbl       (lhbl),
    .lvbl       (lvbl),
    .hpos       (hpos),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .line_start (line_start),
    .wr_bank    (wr_bank),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  // Reference model: two line arrays plus the observable outputs.
  logic [7:0] mm [2][512];
  bit         m_init;
  int         m_sweep;
  bit         m_busy;
  bit         m_rdb;
  bit         m_lhbl_q;
  bit         m_ls;
  bit         m_rd_valid;
  logic [7:0] m_rd_data;
  bit         m_clr;
  int         m_clr_addr;
  bit         m_clr_bank;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_init     = 1'b1;
    m_sweep    = 0;
    m_busy     = 1'b1;
    m_rdb      = 1'b0;
    m_lhbl_q   = 1'b0;
    m_ls       = 1'b0;
    m_rd_valid = 1'b0;
    m_rd_data  = 8'h00;
    m_clr      = 1'b0;
  endfunction

  function automatic void model_step();
    bit         active;
    logic [7:0] val;
    m_ls = 1'b0;
    if (m_init) begin
      mm[0][m_sweep] = 8'h00;
      mm[1][m_sweep] = 8'h00;
      m_sweep++;
      if (m_sweep == 320) begin
        m_init = 1'b0;
        m_busy = 1'b0;
      end
      if (pxl_cen) m_lhbl_q = lhbl;
      return;
    end
    active = pxl_cen && lhbl && lvbl && (int'(hpos) < 320);
    val    = active ? mm[m_rdb][hpos] : 8'h00;
    if (wr_en && int'(wr_addr) < 320 && wr_data != 8'h00)
      mm[!m_rdb][wr_addr] = wr_data;
    if (m_clr)
      mm[m_clr_bank][m_clr_addr] = 8'h00;
    m_clr      = active;
    m_clr_addr = int'(hpos);
    m_clr_bank = m_rdb;
    if (pxl_cen) begin
      m_rd_valid = active;
      m_rd_data  = val;
      if (m_lhbl_q && !lhbl) begin
        m_rdb = !m_rdb;
        m_ls  = 1'b1;
      end
      m_lhbl_q = lhbl;
    end
  endfunction

  task automatic compare_all();
    chk("busy",       32'(busy),       32'(m_busy));
    chk("line_start", 32'(line_start), 32'(m_ls));
    chk("wr_bank",    32'(wr_bank),    32'(!m_rdb));
    chk("rd_valid",   32'(rd_valid),   32'(m_rd_valid));
    chk("rd_data",    32'(rd_data),    32'(m_rd_data));
  endtask

  task automatic tick(input bit cen, input bit force_w);
    @(negedge clk);
    pxl_cen = cen;
    if (force_w) begin
      wr_en   = 1'b1;
      wr_addr = 9'd9;
      wr_data = 8'($urandom_range(1, 255));
    end else begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 9'($urandom_range(0, 335));
      wr_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    compare_all();
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_busy",     32'(busy),     32'(1));
    chk("rst_rd_data",  32'(rd_data),  32'(0));
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic run_line(input bit vb, input bit do_rst);
    for (int hp = 0; hp < 384; hp++) begin
      int gap;
      gap  = $urandom_range(2, 4);
      hpos = 9'(hp);
      lhbl = (hp < 330);
      lvbl = !vb;
      for (int g = 0; g < gap; g++)
        tick(g == gap - 1, (g == gap - 1) && (hp == 330));
      if (do_rst && hp == 100) begin
        chk("pre_rst_valid", 32'(rd_valid), 32'(1));
        mid_reset();
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    pxl_cen = 1'b0;
    lhbl    = 1'b1;
    lvbl    = 1'b1;
    hpos    = 9'd0;
    wr_en   = 1'b0;
    wr_addr = 9'd0;
    wr_data = 8'h00;
    model_reset();
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b0);
    reset = 1'b0;
    for (int ln = 0; ln < 14; ln++)
      run_line(ln == 6 || ln == 7, ln == 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_linebuf.md
Name: video_linebuf

Overview:
- Double-buffered (ping-pong) pixel line buffer sitting directly downstream of the video timing generator.
- The object renderer fills one bank for the next line (addressed by vrender) while the other bank is scanned out against hpos.
- Banks swap at every horizontal blank start.
- Scanned pixels are cleared behind the beam, so each bank is blank when it returns to the writer.

Parameters:
- DW, 8, pixel data width (palette index + priority bits).
- AW, 9, line address width.
- HACTIVE, 320, active pixels per line; valid addresses are 0..HACTIVE-1.
- TRANSP, 0, transparent/clear pixel value.

Ports:
- clk  in  1  pixel-domain clock (96 MHz video clock).
- reset  in  1  asynchronous, active-high reset.
- pxl_cen  in  1  pixel clock enable.
- lhbl  in  1  horizontal blank, active low.
- lvbl  in  1  vertical blank, active low.
- hpos  in  9  current scan-out pixel column.
- wr_en  in  1  renderer write strobe, one pixel per clk.
- wr_addr  in  AW  renderer pixel column.
- wr_data  in  DW  renderer pixel value.
- busy  out  1  init sweep in progress; writes are ignored.
- line_start  out  1  one-clk pulse on bank swap.
- wr_bank  out  1  bank currently owned by the writer.
- rd_data  out  DW  scanned-out pixel.
- rd_valid  out  1  rd_data is an active-area pixel.

Behaviour:
- Reset (async): enter INIT. Register values while reset is asserted and on its release:
  - rd_bank=0, wr_bank=1
  - rd_data=TRANSP, rd_valid=0, line_start=0, busy=1
  - sweep address=0, lhbl history=0.
- FSM INIT:
  - Each clk (ignoring pxl_cen), write TRANSP to the sweep address in both banks, then increment.
  - After address HACTIVE-1 is written, go to RUN on the next clk and drop busy; the INIT sweep is HACTIVE clks.
  - In INIT: wr_en is ignored, rd_data=TRANSP, rd_valid=0, and no swaps occur (lhbl history still tracks).
- FSM RUN: no exit except reset. Reset mid-line or mid-frame restarts INIT.
- Swap:
  - Sample lhbl on pxl_cen clks.
  - A 1->0 transition (entering hblank) toggles rd_bank at that edge; wr_bank is always ~rd_bank.
  - line_start=1 for exactly that clk.
  - Swaps occur in vertical blank too.
- Writer:
  - On wr_en and RUN, write wr_data into wr_bank at wr_addr only if wr_addr<HACTIVE and wr_data!=TRANSP.
  - Out-of-range or transparent writes are dropped, so the first opaque write to a column wins until overwritten.
  - A write in the same clk as a swap uses the pre-swap wr_bank.
  - Writes are not gated by pxl_cen.
- Reader:
  - On a pxl_cen clk with lhbl&lvbl=1 and hpos<HACTIVE, capture mem[rd_bank][hpos] into rd_data and set rd_valid=1.
  - Latency: one pxl_cen tick.
  - Otherwise, on pxl_cen: rd_data=TRANSP, rd_valid=0.
  - Outputs hold between pxl_cen ticks.
- Clear-behind:
  - On the clk after each active read, write TRANSP to the same address in rd_bank (latched address and bank).
  - This avoids read-during-write, and the clear completes even if a swap occurred on that clk.
- Port arbitration:
  - Each bank has a single port. The writer only touches wr_bank; the reader and clear only touch rd_bank.
  - No conflicts exist except in INIT, where the sweep owns both ports.
- hpos wrap past 511 is irrelevant: any hpos>=HACTIVE is treated as blank.

Decomposition:
- Package video_pkg:
  - constants PXL_DW=8, LINE_AW=9, H_ACTIVE=320, PXL_TRANSP=0
  - typedef pixel_t (DW bits), typedef lineaddr_t (AW bits)
  - FSM enum {ST_INIT, ST_RUN}.
- Sub-module linebuf_bank: single-port synchronous RAM, 2^AW x DW, with we, addr, din, and registered dout. Instantiated twice; top-level muxes each port by bank ownership/INIT.

Test Plan:
- Reset release: busy=1 for exactly 320 clks, then 0; rd_data=0 and rd_valid=0 throughout; readback of both banks at 0..319 = 0.
- Fill and swap: write wr_addr=5, data=0x3C into wr_bank=1; force lhbl 1->0 -> line_start pulses 1 clk and rd_bank=1. Next active line at hpos=5 -> rd_data=0x3C one pxl_cen later, rd_valid=1.
- Clear-behind: after the line above, swap twice and re-read hpos=5 -> rd_data=0.
- Transparency/clip: write data 0x00 at addr 7 over an existing 0x11 -> remains 0x11. Write 0x22 at addr 320 -> dropped, and no other address changes.
- Simultaneous write and swap: wr_en on the swap clk at addr 9 -> data lands in the old wr_bank and is visible on the line immediately scanned out.
- Reset mid-line: assert reset while rd_valid=1 at hpos=100 -> rd_valid=0 immediately, INIT restarts, and all pixels read 0 afterwards.
